float_to_int16: RTL and testbench

FLOAT_TO_INT16 -- requirements
Module: float_to_int16

---
 rtl/float_to_int16_pkg.sv | 28 ++
 rtl/f2i_mag_shift.sv | 17 +
 rtl/float_to_int16.sv | 141 ++++++++++++++
 tb/tb_float_to_int16.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/float_to_int16_pkg.sv
// Shared constants and operand classification for the float -> int16 converter.
package float_to_int16_pkg;

  localparam int EXP_BIAS = 127;
  localparam logic [15:0] INT16_MAX = 16'h7FFF;
  localparam logic [15:0] INT16_MIN = 16'h8000;
  localparam int FRAC_W = 23;

  // Significand with the hidden one, and the magnitude width after the shift.
  localparam int SIG_W = FRAC_W + 1;
  localparam int MAG_W = 16;

  // Exponent landmarks used by the classifier.
  localparam logic [7:0] EXP_ALL_ONES = 8'hFF;
  localparam logic [7:0] EXP_P0 = 8'(EXP_BIAS);
  localparam logic [7:0] EXP_P14 = 8'(EXP_BIAS + 14);
  localparam logic [7:0] EXP_P15 = 8'(EXP_BIAS + 15);
  // Right-shift amount is (FRAC_W - p) = (EXP_BIAS + FRAC_W) - e.
  localparam logic [7:0] SHIFT_BASE = 8'(EXP_BIAS + FRAC_W);

  typedef enum logic [1:0] {
    ZERO_SMALL,
    NORMAL,
    SATURATE,
    NAN
  } op_class_e;

endpackage

// File: rtl/f2i_mag_shift.sv
// Right-shifts the 24-bit significand so that only the integer part remains,
// returning the low 16 bits as the unsigned magnitude.
module f2i_mag_shift
  import float_to_int16_pkg::*;
(
  input  logic [SIG_W-1:0] sig_i,
  input  logic [4:0]       shamt_i,
  output logic [MAG_W-1:0] mag_o
);

  logic [SIG_W-1:0] shifted;

  // Shift amounts of 8..23 keep every integer bit inside the 16-bit window.
  assign shifted = sig_i >> shamt_i;
  assign mag_o   = shifted[MAG_W-1:0];

endmodule

// File: rtl/float_to_int16.sv
// IEEE-754 single to int16 converter, truncating toward zero, with saturation
// and NaN flagging. Two-stage valid/ready pipeline:
//   S1 classifies the operand and registers the shifted magnitude;
//   S2 applies the sign, saturates and registers the outputs.
module float_to_int16
  import float_to_int16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] float_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] int_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
  output logic        invalid
);

  logic              enable;

  logic              sign_w;
  logic [7:0]        exp_w;
  logic [FRAC_W-1:0] frac_w;
  logic              frac_nz;
  logic [7:0]        shift_diff;

  op_class_e         s1_cls_d;
  logic [4:0]        s1_shamt_d;
  logic [MAG_W-1:0]  s1_mag_d;

  logic              s1_valid_q;
  logic              s1_sign_q;
  op_class_e         s1_cls_q;
  logic [MAG_W-1:0]  s1_mag_q;

  logic [15:0]       int_d;
  logic              ovf_d;
  logic              inv_d;

  logic [15:0]       int_q;
  logic              ovf_q;
  logic              inv_q;
  logic              out_valid_q;

  // The whole pipeline moves together; a full, stalled output freezes both stages.
  assign enable   = !out_valid_q || out_ready;
  assign in_ready = enable;

  assign sign_w     = float_in[31];
  assign exp_w      = float_in[30:23];
  assign frac_w     = float_in[FRAC_W-1:0];
  assign frac_nz    = |frac_w;
  assign shift_diff = SHIFT_BASE - exp_w;

  // Classify the operand and choose the significand shift for in-range values.
  always_comb begin
    s1_cls_d   = ZERO_SMALL;
    s1_shamt_d = 5'd0;
    if (exp_w == EXP_ALL_ONES) begin
      s1_cls_d = frac_nz ? NAN : SATURATE;
    end else if (exp_w < EXP_P0) begin
      s1_cls_d = ZERO_SMALL;
    end else if (exp_w <= EXP_P14) begin
      s1_cls_d   = NORMAL;
      s1_shamt_d = shift_diff[4:0];
    end else if ((exp_w == EXP_P15) && sign_w && !frac_nz) begin
      // Exactly -32768 is representable; its magnitude 0x8000 fits the 16-bit window.
      s1_cls_d   = NORMAL;
      s1_shamt_d = shift_diff[4:0];
    end else begin
      s1_cls_d = SATURATE;
    end
  end

  f2i_mag_shift u_mag_shift (
    .sig_i   ({1'b1, frac_w}),
    .shamt_i (s1_shamt_d),
    .mag_o   (s1_mag_d)
  );

  // S1 register: class, sign and magnitude of the accepted operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_cls_q   <= ZERO_SMALL;
      s1_mag_q   <= '0;
    end else if (enable) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= sign_w;
        s1_cls_q  <= s1_cls_d;
        s1_mag_q  <= s1_mag_d;
      end
    end
  end

  // Apply sign and saturation for the S1 contents.
  always_comb begin
    int_d = 16'h0000;
    ovf_d = 1'b0;
    inv_d = 1'b0;
    case (s1_cls_q)
      ZERO_SMALL: int_d = 16'h0000;
      NORMAL:     int_d = s1_sign_q ? (~s1_mag_q + 16'd1) : s1_mag_q;
      SATURATE: begin
        int_d = s1_sign_q ? INT16_MIN : INT16_MAX;
        ovf_d = 1'b1;
      end
      NAN: begin
        int_d = 16'h0000;
        inv_d = 1'b1;
      end
      default: int_d = 16'h0000;
    endcase
  end

  // S2 register: outputs only change when a valid S1 entry moves forward.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      int_q       <= '0;
      ovf_q       <= 1'b0;
      inv_q       <= 1'b0;
    end else if (enable) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        int_q <= int_d;
        ovf_q <= ovf_d;
        inv_q <= inv_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign int_out   = int_q;
  assign overflow  = ovf_q;
  assign invalid   = inv_q;

endmodule

// File: tb/tb_float_to_int16.sv
// Scoreboard bench for float_to_int16: the stimulus side records the expected
// result when an operand is accepted; the monitor pops and compares on each
// output transfer, and also watches stall stability.
module tb_float_to_int16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] float_in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] int_out;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        invalid;

  typedef struct packed {
    logic [15:0] val;
    logic        ovf;
    logic        inv;
  } exp_t;

  exp_t sb[$];
  exp_t exp_cur;

  int checks = 0;
  int errors = 0;

  logic        stall_prev = 1'b0;
  logic [15:0] held_int;
  logic        held_ovf;
  logic        held_inv;

  always #5 clk = ~clk;

  float_to_int16 dut (
    .clk       (clk),
    .rst       (rst),
    .float_in  (float_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .int_out   (int_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .invalid   (invalid)
  );

  // Monitor: inputs change at posedge+2, so everything is stable at negedge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!(out_valid && int_out == held_int && overflow == held_ovf && invalid == held_inv)) begin
          errors++;
          $display("FAIL hold: got v=%0b %h o=%0b i=%0b, need v=1 %h o=%0b i=%0b",
                   out_valid, int_out, overflow, invalid, held_int, held_ovf, held_inv);
        end
      end
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL in_ready_stall: got %0b, need 0", in_ready);
        end
        stall_prev = 1'b1;
        held_int = int_out;
        held_ovf = overflow;
        held_inv = invalid;
      end else begin
        stall_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %h o=%0b i=%0b, need none", int_out, overflow, invalid);
        end else begin
          e = sb.pop_front();
          if (int_out !== e.val || overflow !== e.ovf || invalid !== e.inv) begin
            errors++;
            $display("FAIL result: got %h o=%0b i=%0b, need %h o=%0b i=%0b",
                     int_out, overflow, invalid, e.val, e.ovf, e.inv);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(exp_cur);
    end
  end

  function automatic logic [31:0] i2f(input int v);
    logic        s;
    logic [16:0] m;
    logic [39:0] t;
    int          k;
    if (v == 0) return 32'h0;
    s = (v < 0);
    m = s ? 17'(-v) : 17'(v);
    k = 0;
    for (int b = 0; b < 17; b++) if (m[b]) k = b;
    t = 40'(m) << (23 - k);
    return {s, 8'(127 + k), t[22:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s: got %h, need %h", name, got, need);
    end
  endtask

  // Present one operand and hold it until accepted; returns at posedge+2.
  task automatic send(input logic [31:0] f, input logic [15:0] v, input logic o, input logic i);
    int n;
    float_in = f;
    exp_cur  = '{val: v, ovf: o, inv: i};
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0, need 1");
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #2;
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  typedef struct {
    logic [31:0] f;
    logic [15:0] v;
    logic        o;
    logic        i;
  } vec_t;

  vec_t vecs[$] = '{
    '{32'h46FFFE00, 16'h7FFF, 1'b0, 1'b0},
    '{32'hC7000000, 16'h8000, 1'b0, 1'b0},
    '{32'h47000000, 16'h7FFF, 1'b1, 1'b0},
    '{32'h3FC00000, 16'h0001, 1'b0, 1'b0},
    '{32'hBFC00000, 16'hFFFF, 1'b0, 1'b0},
    '{32'h3F000000, 16'h0000, 1'b0, 1'b0},
    '{32'h80000000, 16'h0000, 1'b0, 1'b0},
    '{32'h7FC00000, 16'h0000, 1'b0, 1'b1},
    '{32'h7F800000, 16'h7FFF, 1'b1, 1'b0},
    '{32'hFF800000, 16'h8000, 1'b1, 1'b0},
    '{32'h00000001, 16'h0000, 1'b0, 1'b0},
    '{32'h42F60000, 16'h007B, 1'b0, 1'b0},
    '{32'hC2F6E666, 16'hFF85, 1'b0, 1'b0},
    '{32'h46FFFFFF, 16'h7FFF, 1'b0, 1'b0},
    '{32'hC7000001, 16'h8000, 1'b1, 1'b0},
    '{32'h7F7FFFFF, 16'h7FFF, 1'b1, 1'b0},
    '{32'hFFC00001, 16'h0000, 1'b0, 1'b1},
    '{32'h3F800000, 16'h0001, 1'b0, 1'b0}
  };

  initial begin
    rst       = 1'b1;
    float_in  = 32'h0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    exp_cur   = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_int_out", 32'(int_out), 32'd0);
    check("rst_flags", 32'({overflow, invalid}), 32'd0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk);
    #2;

    // Latency from acceptance to out_valid with an empty pipeline.
    send(32'h40000000, 16'h0002, 1'b0, 1'b0);
    @(negedge clk);
    check("latency_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("latency_cycle2", 32'(out_valid), 32'd1);
    @(posedge clk);
    #2;

    foreach (vecs[k]) send(vecs[k].f, vecs[k].v, vecs[k].o, vecs[k].i);
    drain();

    // Backpressure: out_ready low on stream cycles 3-5.
    fork
      begin
        send(32'h3F800000, 16'd1, 1'b0, 1'b0);
        send(32'h40000000, 16'd2, 1'b0, 1'b0);
        send(32'h40400000, 16'd3, 1'b0, 1'b0);
        send(32'h40800000, 16'd4, 1'b0, 1'b0);
      end
      begin
        for (int c = 1; c <= 10; c++) begin
          out_ready = !(c >= 3 && c <= 5);
          @(posedge clk);
          #2;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with two operands held in flight behind a stalled output.
    out_ready = 1'b0;
    send(32'h3F800000, 16'd1, 1'b0, 1'b0);
    send(32'h40000000, 16'd2, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_int_out", 32'(int_out), 32'd0);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_no_valid", 32'(out_valid), 32'd0);
    repeat (4) @(negedge clk);
    check("midrst_no_stale", 32'(out_valid), 32'd0);
    @(posedge clk);
    #2;
    send(32'h40400000, 16'd3, 1'b0, 1'b0);
    drain();

    // Round trip of every int16 value.
    for (int v = -32768; v <= 32767; v++) send(i2f(v), 16'(v), 1'b0, 1'b0);
    drain();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
